// File: rtl/wdt_pkg.sv
// wdt_pkg: register map, kick FSM states and STATUS bit positions for wdt_ctrl
package wdt_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_KICK   = 4'h4;
    localparam logic [3:0] ADDR_TOCNT  = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;
    localparam int ST_PEND = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_WTO  = 2;
    typedef enum logic {IDLE, HOLD} kick_state_e;
endpackage

// File: rtl/wdt_if.sv
// wdt_if: simple one-cycle request bus with registered read return
interface wdt_if;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    modport master (output req, we, addr, wdata, input rdata, rvalid);
    modport slave (input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/wdt_sync.sv
// wdt_sync: multi-flop synchronizer for a single clk2-domain signal
module wdt_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst)
        if (!rst) chain <= '0;
        else      chain <= {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: bus register front-end driving the clk2 watchdog and latching its timeout as irq
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int KICK_HOLD   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    wdt_if.slave        bus,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        WTO,
    output logic        irq
);
    localparam int CW = KICK_HOLD > 1 ? $clog2(KICK_HOLD) : 1;
    kick_state_e state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic [3:0] word;
    logic wr, rd, wr_ctrl, wr_kick, wr_tocnt, wr_status;
    logic wto_s, wto_d, busy;
    logic [31:0] status, rd_val;
    assign word      = bus.addr & 4'b1100;
    assign wr        = bus.req & bus.we;
    assign rd        = bus.req & ~bus.we;
    assign wr_ctrl   = wr && word == ADDR_CTRL;
    assign wr_kick   = wr && word == ADDR_KICK;
    assign wr_tocnt  = wr && word == ADDR_TOCNT;
    assign wr_status = wr && word == ADDR_STATUS;
    assign busy      = state == HOLD;
    assign WDLIVE    = busy;
    wdt_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(WTO), .q(wto_s));
    // Abort beats a same-cycle kick; a kick only counts while the watchdog is enabled
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        if (wr_ctrl && !bus.wdata[0]) begin
            nstate = IDLE;
        end else if (wr_kick && WDEN) begin
            nstate = HOLD;
            ncnt   = CW'(KICK_HOLD - 1);
        end else if (busy) begin
            nstate = cnt == '0 ? IDLE : HOLD;
            ncnt   = cnt == '0 ? cnt : cnt - 1'b1;
        end
    end
    always_comb begin
        status          = '0;
        status[ST_PEND] = irq;
        status[ST_BUSY] = busy;
        status[ST_WTO]  = wto_s;
        rd_val = word == ADDR_CTRL  ? {31'b0, WDEN} :
                 word == ADDR_KICK  ? {31'b0, busy} :
                 word == ADDR_TOCNT ? WTOCNT : status;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            WDEN       <= 1'b0;
            WTOCNT     <= '0;
            wto_d      <= 1'b0;
            irq        <= 1'b0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            state      <= nstate;
            cnt        <= ncnt;
            wto_d      <= wto_s;
            bus.rvalid <= rd;
            if (rd) bus.rdata <= rd_val;
            if (wr_ctrl) WDEN <= bus.wdata[0];
            if (wr_tocnt && !WDEN) WTOCNT <= bus.wdata;
            irq <= (wto_s & ~wto_d) | (irq & ~(wr_status & bus.wdata[ST_PEND]));
        end
endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: directed self-checking bench for wdt_ctrl
module tb_wdt_ctrl;
    import wdt_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic WDEN, WDLIVE, WTO, irq;
    logic [31:0] WTOCNT;
    int checks = 0;
    int fails = 0;
    int high;
    wdt_if bus ();
    wdt_ctrl #(.KICK_HOLD(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .WDEN(WDEN), .WDLIVE(WDLIVE),
        .WTOCNT(WTOCNT), .WTO(WTO), .irq(irq)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string tag, input logic [31:0] exp);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.req = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
        chk(tag, bus.rdata, exp);
    endtask

    task automatic count_high();
        int n = 0;
        while (WDLIVE && n < 50) begin
            high++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; WTO = 1'b0;
        #1;
        chk("rst_wden", {31'b0, WDEN}, 32'd0);
        chk("rst_wdlive", {31'b0, WDLIVE}, 32'd0);
        chk("rst_wtocnt", WTOCNT, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(ADDR_CTRL, "rd_ctrl0", 32'd0);
        rd(ADDR_KICK, "rd_kick0", 32'd0);
        rd(ADDR_TOCNT, "rd_tocnt0", 32'd0);
        rd(ADDR_STATUS, "rd_status0", 32'd0);
        @(negedge clk);
        chk("rvalid_pulse", {31'b0, bus.rvalid}, 32'd0);
        // TOCNT is frozen while enabled
        wr(ADDR_TOCNT, 32'h100);
        chk("wtocnt_set", WTOCNT, 32'h100);
        wr(ADDR_CTRL, 32'h1);
        chk("wden_set", {31'b0, WDEN}, 32'd1);
        wr(ADDR_TOCNT, 32'h5);
        chk("wtocnt_locked", WTOCNT, 32'h100);
        rd(ADDR_TOCNT, "rd_tocnt_locked", 32'h100);
        rd(4'h9, "rd_addr_lowbits", 32'h100);
        chk("rdata_hold", bus.rdata, 32'h100);
        // single kick
        high = 0;
        wr(ADDR_KICK, 32'hDEAD);
        count_high();
        chk("kick_len8", high, 32'd8);
        wr(ADDR_KICK, 32'h0);
        rd(ADDR_STATUS, "rd_status_busy", 32'h2);
        rd(ADDR_KICK, "rd_kick_busy", 32'h1);
        high = 0;
        count_high();
        rd(ADDR_KICK, "rd_kick_idle", 32'h0);
        // re-kick in the 5th high cycle
        high = 0;
        wr(ADDR_KICK, 32'h1);
        high = 1;
        repeat (4) begin
            @(negedge clk);
            high += int'(WDLIVE);
        end
        wr(ADDR_KICK, 32'h1);
        count_high();
        chk("rekick_len13", high, 32'd13);
        // abort by disabling
        wr(ADDR_KICK, 32'h1);
        @(negedge clk);
        chk("abort_pre", {31'b0, WDLIVE}, 32'd1);
        wr(ADDR_CTRL, 32'h0);
        chk("abort_wdlive", {31'b0, WDLIVE}, 32'd0);
        chk("abort_wden", {31'b0, WDEN}, 32'd0);
        wr(ADDR_KICK, 32'h1);
        chk("kick_disabled", {31'b0, WDLIVE}, 32'd0);
        @(negedge clk);
        chk("kick_disabled2", {31'b0, WDLIVE}, 32'd0);
        // WTO latency: irq appears on the 3rd edge
        WTO = 1'b1;
        @(negedge clk);
        chk("wto_e1", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("wto_e2", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("wto_e3", {31'b0, irq}, 32'd1);
        rd(ADDR_STATUS, "rd_status_pend", 32'h5);
        WTO = 1'b0;
        repeat (4) @(negedge clk);
        chk("pend_sticky", {31'b0, irq}, 32'd1);
        // W1C lands on the same edge as a new set: set wins
        WTO = 1'b1;
        repeat (2) @(negedge clk);
        wr(ADDR_STATUS, 32'h1);
        chk("set_wins", {31'b0, irq}, 32'd1);
        @(negedge clk);
        chk("set_wins2", {31'b0, irq}, 32'd1);
        wr(ADDR_STATUS, 32'h1);
        chk("w1c_clear", {31'b0, irq}, 32'd0);
        rd(ADDR_STATUS, "rd_status_clr", 32'h4);
        // async reset mid-kick with irq pending
        WTO = 1'b0;
        repeat (3) @(negedge clk);
        WTO = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_again", {31'b0, irq}, 32'd1);
        wr(ADDR_CTRL, 32'h1);
        wr(ADDR_KICK, 32'h1);
        chk("hold_before_rst", {31'b0, WDLIVE}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_wdlive", {31'b0, WDLIVE}, 32'd0);
        chk("arst_wden", {31'b0, WDEN}, 32'd0);
        chk("arst_irq", {31'b0, irq}, 32'd0);
        chk("arst_wtocnt", WTOCNT, 32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        chk("arst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/wdt_ctrl.md
# wdt_ctrl

Register front-end for the watchdog timer, in the CPU clock domain, directly upstream of the watchdog. It turns simple bus writes into the watchdog's control inputs: the enable level, a stretched kick pulse and the timeout count. It also brings the watchdog's timeout output back into this clock domain and latches it as a sticky interrupt. The watchdog runs on the slower clk2, so every control output is held stable or stretched long enough for that domain to sample it.

## Interface
- KICK_HOLD, 8, cycles WDLIVE is held high per kick; must be ≥ 2×(clk/clk2 ratio)+1
- SYNC_STAGES, 2, flops in the WTO synchronizer (≥2)
- clk  in  1  CPU clock
- rst  in  1  reset; asynchronous, active-low
- req  in  1  bus access strobe, one-cycle
- we  in  1  1 = write, 0 = read (qualified by req)
- addr  in  4  byte address, bits [1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, valid with rvalid
- rvalid  out  1  one-cycle pulse, cycle after a read req
- WDEN  out  1  watchdog enable level
- WDLIVE  out  1  kick, stretched pulse
- WTOCNT  out  32  timeout count to watchdog
- WTO  in  1  watchdog timeout, asynchronous to clk
- irq  out  1  timeout interrupt (sticky pending)

## Operation
- Register map (word offsets):
  - 0x0 CTRL: bit0 WDEN, RW.
  - 0x4 KICK: a write of any value starts a kick. A read returns {31'b0, busy}.
  - 0x8 TOCNT: RW 32-bit. A write is ignored while WDEN=1, so the value is quasi-static whenever the clk2 domain uses it.
  - 0xC STATUS: bit0 pending (write 1 to clear), bit1 kick busy (RO), bit2 synchronized WTO (RO).
  - Unmapped: writes ignored, reads return 0.
- Kick FSM:
  - IDLE: WDLIVE=0. A KICK write moves to HOLD and loads the counter with KICK_HOLD-1.
  - HOLD: WDLIVE=1. The counter decrements each cycle; at 0 the FSM returns to IDLE.
  - A KICK write in HOLD reloads the counter and stays in HOLD.
  - A CTRL write with bit0=0 in HOLD aborts to IDLE.
  - A KICK write while WDEN=0 is ignored.
- WTO path:
  - WTO passes through a SYNC_STAGES flop chain, then a one-flop delay for edge detect.
  - A rising edge of the synchronized WTO sets pending. irq = pending.
  - If a W1C and a set edge land in the same cycle, set wins.
  - Clearing WDEN does not clear pending.
- Counter width is ceil(log2(KICK_HOLD)); no wrap, because HOLD exits at 0.

## Timing
- Reset values: WDEN=0, WDLIVE=0, WTOCNT=0, rdata=0, rvalid=0, irq=0, FSM=IDLE, sync chain=0.
- A write takes effect on the clock edge that samples req&we; the new output is visible the following cycle.
- Read: rvalid and rdata are registered and appear the cycle after req. rdata holds until the next read.
- Kick: WDLIVE rises the cycle after the KICK write and stays high for exactly KICK_HOLD cycles (no re-kick).
- WTO→irq: irq rises SYNC_STAGES+1 clk edges after WTO rises (3 edges by default).
- Reset asserted mid-kick: WDLIVE drops immediately, asynchronously.
- Back-to-back req on every cycle is legal; each is serviced independently.

## Structure
- Package wdt_pkg holds:
  - the address constants ADDR_CTRL, ADDR_KICK, ADDR_TOCNT, ADDR_STATUS;
  - the kick_state_e enum {IDLE, HOLD};
  - STATUS bit indices.
- One sub-module, wdt_sync: a parameterized SYNC_STAGES flop chain with asynchronous active-low reset. It is reused for any future clk2→clk signal.

## Test plan
- Reset, then read all four registers → 0, 0, 0, 0; irq=0, WDLIVE=0.
- Write TOCNT=0x100, then CTRL=1, then TOCNT=0x5 → WTOCNT stays 0x100 and reads back 0x100; WDEN=1.
- KICK write with KICK_HOLD=8 → WDLIVE high for exactly 8 cycles, STATUS.busy=1 throughout. A re-kick at cycle 5 extends the pulse to a total of 13 cycles.
- Kick, then write CTRL=0 two cycles later → WDLIVE low on the next cycle; a subsequent KICK write leaves WDLIVE=0.
- Raise WTO → irq high at the 3rd edge. Write STATUS=1 on the same cycle as a second WTO rising edge → pending stays 1. A later clean W1C → irq=0.
- Assert rst mid-HOLD with irq=1 → all outputs 0 immediately, without waiting for a clock edge.
